// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, command codes and default payload width for the SPI slave.
package spi_pkg;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD} state_t;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_tx_shift.sv
// spi_tx_shift: MSB-first MISO serialiser; the register empties to zero whenever it is neither loaded nor shifting.
module spi_tx_shift import spi_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              miso
);
    logic [DATA_W-1:0] sr;
    always_ff @(posedge clk)
        sr <= !rst_n ? '0 : load ? data : shift ? sr << 1 : '0;
    assign miso = sr[DATA_W-1];
endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave clocked by clk, decoding {cmd[1:0], payload} frames and
// serving one read word per read-address/read-data pair.
module spi_slave_param import spi_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              cmd_err,
    output logic              rd_pending
);
    // One counter serves frame bits, the WAIT_TX timeout and the SEND bit count.
    localparam int CW = $clog2((DATA_W + 3 > TX_TIMEOUT + 1) ? DATA_W + 3 : TX_TIMEOUT + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_W:0] sr;
    logic [1:0] cmd;
    logic capture, done, bad, timeout, load, shift;
    assign capture = !SS_n && state inside {CHK_CMD, WRITE, READ_ADD, READ_DATA};
    always_comb begin
        state_n = SS_n ? IDLE : state;
        cnt_n = '0;
        cmd = {sr[0], MOSI};
        done = 1'b0;
        bad = 1'b0;
        timeout = 1'b0;
        load = 1'b0;
        shift = 1'b0;
        if (!SS_n) begin
            case (state)
                IDLE: state_n = CHK_CMD;
                CHK_CMD: begin
                    state_n = !MOSI ? WRITE : rd_pending ? READ_DATA : READ_ADD;
                    cnt_n = cnt + CW'(1);
                end
                WRITE, READ_ADD, READ_DATA: begin
                    bad = cnt == CW'(1) && (state == WRITE ? !(cmd inside {CMD_WR_ADDR, CMD_WR_DATA}) :
                          state == READ_ADD ? cmd != CMD_RD_ADDR : cmd != CMD_RD_DATA);
                    done = cnt == CW'(DATA_W + 1);
                    state_n = bad ? HOLD : !done ? state : state == READ_DATA ? WAIT_TX : HOLD;
                    cnt_n = done ? '0 : cnt + CW'(1);
                end
                WAIT_TX: begin
                    load = tx_valid;
                    timeout = TX_TIMEOUT != 0 && !tx_valid && cnt == CW'(TX_TIMEOUT - 1);
                    state_n = load ? SEND : timeout ? HOLD : WAIT_TX;
                    cnt_n = load ? CW'(1) : cnt + CW'(1);
                end
                SEND: begin
                    shift = 1'b1;
                    state_n = cnt == CW'(DATA_W) ? HOLD : SEND;
                    cnt_n = cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            cmd_err <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sr <= capture ? {sr[DATA_W-1:0], MOSI} : '0;
            rx_valid <= done;
            cmd_err <= bad || timeout;
            if (done)
                rx_data <= {sr, MOSI};
            if (done && state == READ_ADD)
                rd_pending <= 1'b1;
            if (done && state == READ_DATA)
                rd_pending <= 1'b0;
        end
    end
    spi_tx_shift #(.DATA_W(DATA_W)) u_tx (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .shift(shift),
        .data(tx_data),
        .miso(MISO)
    );
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: directed frames for spi_slave_param (DATA_W=8, TX_TIMEOUT=16) with hand-computed expectations.
module tb_spi_slave_param;
    logic clk = 1'b0;
    logic rst_n, SS_n, MOSI, tx_valid, MISO, rx_valid, cmd_err, rd_pending;
    logic [7:0] tx_data;
    logic [9:0] rx_data;
    int n_checks = 0;
    int n_errors = 0;
    int vseen, eseen, mseen;
    logic [7:0] txb;

    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .tx_valid(tx_valid),
        .tx_data(tx_data), .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_err(cmd_err), .rd_pending(rd_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        SS_n = 1'b0;
        tick();
    endtask

    task automatic stop();
        SS_n = 1'b1;
        tick();
    endtask

    // Drives the top n bits of f MSB first, tallying rx_valid and cmd_err highs.
    task automatic bits(input logic [9:0] f, input int n);
        vseen = 0;
        eseen = 0;
        for (int i = 9; i > 9 - n; i--) begin
            MOSI = f[i];
            tick();
            vseen += int'(rx_valid);
            eseen += int'(cmd_err);
        end
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tick(); tick();
        chk("rst_miso", MISO, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_rd_pending", rd_pending, 0);
        rst_n = 1'b1;
        tick();

        // Write frame 00 + A5; then HOLD ignores MOSI.
        start(); bits(10'h0A5, 10);
        chk("wr_valid", rx_valid, 1);
        chk("wr_data", rx_data, 10'h0A5);
        chk("wr_vcount", vseen, 1);
        bits(10'h3FF, 6);
        chk("hold_no_valid", vseen, 0);
        chk("hold_data", rx_data, 10'h0A5);
        stop();

        // Read address then read data with tx word 0x96.
        start(); bits(10'h23C, 10);
        chk("ra_data", rx_data, 10'h23C);
        chk("ra_pending", rd_pending, 1);
        stop();
        chk("ra_persist", rd_pending, 1);
        start(); bits(10'h300, 10);
        chk("rd_data", rx_data, 10'h300);
        chk("rd_pending_clr", rd_pending, 0);
        chk("wait_miso", MISO, 0);
        txb = 8'h96;
        tx_valid = 1'b1; tx_data = txb;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            chk($sformatf("miso_bit%0d", i), MISO, txb[i]);
            if (i > 0) tick();
        end
        tick();
        chk("miso_after_send", MISO, 0);
        stop();

        // Bad command: bits 1,1 with nothing pending.
        start(); bits(10'h3FF, 2);
        chk("bad_err", cmd_err, 1);
        chk("bad_no_valid", vseen, 0);
        bits(10'h0FF, 8);
        chk("bad_err_once", eseen, 0);
        chk("bad_hold_no_valid", vseen, 0);
        stop();

        // Aborted write, then a clean write.
        start(); bits(10'h0FF, 5);
        stop();
        chk("abort_no_valid", vseen + int'(rx_valid), 0);
        start(); bits(10'h15A, 10);
        chk("after_abort_data", rx_data, 10'h15A);
        chk("after_abort_vcount", vseen, 1);
        stop();

        // Aborted read-data frame keeps rd_pending set.
        start(); bits(10'h2AA, 10);
        stop();
        start(); bits(10'h3FF, 4);
        stop();
        chk("abort_rd_pending", rd_pending, 1);

        // Read data with no tx_valid: timeout 16 cycles after WAIT_TX entry.
        start(); bits(10'h3FF, 10);
        chk("to_rx_data", rx_data, 10'h3FF);
        eseen = 0; mseen = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) eseen += int'(cmd_err);
            mseen += int'(MISO);
        end
        chk("to_err_early", eseen, 0);
        chk("to_err16", cmd_err, 1);
        chk("to_miso", mseen, 0);
        tick();
        chk("to_err_pulse", cmd_err, 0);
        stop();

        // Reset during SEND bit 3.
        start(); bits(10'h211, 10);
        stop();
        start(); bits(10'h3AB, 10);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        tick(); tick();
        chk("send_bit3", MISO, 1);
        rst_n = 1'b0; SS_n = 1'b1;
        tick();
        chk("rst_send_miso", MISO, 0);
        chk("rst_send_rx_data", rx_data, 0);
        chk("rst_send_rx_valid", rx_valid, 0);
        chk("rst_send_cmd_err", cmd_err, 0);
        chk("rst_send_pending", rd_pending, 0);
        rst_n = 1'b1;
        tick();

        // Reset mid-frame clears rd_pending; next 11 frame is treated as a bad read address.
        start(); bits(10'h200, 10);
        stop();
        chk("pend_before_rst", rd_pending, 1);
        start(); bits(10'h0F0, 4);
        rst_n = 1'b0; SS_n = 1'b1;
        tick();
        chk("rst_mid_pending", rd_pending, 0);
        rst_n = 1'b1;
        tick();
        start(); bits(10'h3C0, 2);
        chk("post_rst_err", cmd_err, 1);
        stop();
        start(); bits(10'h0C3, 10);
        chk("post_rst_write", rx_data, 10'h0C3);
        stop();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the payload width in bits (range 4..32).
REQ-002 SHALL have parameter TX_TIMEOUT, default 16, meaning the maximum cycles to wait for tx_valid in WAIT_TX (0 disables the timeout).
REQ-003 SHALL have port clk, input, 1 bit: system clock, which is also the serial bit clock; all sampling is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port SS_n, input, 1 bit: slave select, active-low.
REQ-006 SHALL have port MOSI, input, 1 bit: serial data in, MSB first.
REQ-007 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-008 SHALL have port tx_data, input, DATA_W bits: read data to shift out.
REQ-009 SHALL have port MISO, output, 1 bit: serial data out, MSB first, registered.
REQ-010 SHALL have port rx_data, output, DATA_W+2 bits: {cmd[1:0], payload}, registered.
REQ-011 SHALL have port rx_valid, output, 1 bit: single-cycle pulse, rx_data complete.
REQ-012 SHALL have port cmd_err, output, 1 bit: single-cycle pulse on a protocol error.
REQ-013 SHALL have port rd_pending, output, 1 bit: a read address has been accepted and no read data has been issued yet.

Function
REQ-014 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD.
REQ-015 SHALL move IDLE->CHK_CMD on the edge where SS_n=0; in any state, SS_n=1 SHALL force IDLE on the next edge, discarding any partial frame.
REQ-016 SHALL, in CHK_CMD, sample MOSI as frame bit 1 and go to WRITE if it is 0, READ_ADD if it is 1 with rd_pending=0, and READ_DATA if it is 1 with rd_pending=1.
REQ-017 SHALL shift MOSI into a DATA_W+2 shift register every edge from CHK_CMD until DATA_W+2 bits are captured, counted by a bit counter cleared in IDLE.
REQ-018 SHALL check cmd on the edge capturing frame bit 2: WRITE requires 00 or 01, READ_ADD requires 10, READ_DATA requires 11; a mismatch SHALL pulse cmd_err and go to HOLD.
REQ-019 SHALL, on the edge capturing bit DATA_W+2, load rx_data with the frame and assert rx_valid for exactly the following cycle.
REQ-020 WRITE SHALL go to HOLD after the frame completes.
REQ-021 READ_ADD SHALL set rd_pending and go to HOLD after the frame completes.
REQ-022 READ_DATA SHALL clear rd_pending and go to WAIT_TX after the frame completes.
REQ-023 In WAIT_TX, SHALL capture tx_data on the first edge with tx_valid=1, drive MISO=tx_data[DATA_W-1] from that edge, and enter SEND; tx_valid outside WAIT_TX SHALL be ignored.
REQ-024 In SEND, SHALL drive the next lower bit on each edge; after DATA_W bits total have been driven, SHALL go to HOLD and drive MISO=0.
REQ-025 If TX_TIMEOUT>0 and TX_TIMEOUT cycles elapse in WAIT_TX without tx_valid, SHALL pulse cmd_err and go to HOLD.
REQ-026 HOLD SHALL ignore MOSI until SS_n=1.
REQ-027 MISO SHALL be 0 in every state other than SEND and the capture edge of WAIT_TX.
REQ-028 rx_valid and cmd_err SHALL never both be high in the same cycle.
REQ-029 rd_pending SHALL persist across SS_n frames; an aborted READ_DATA frame SHALL leave it set.

Reset
REQ-030 rst_n=0 at an edge SHALL set state IDLE, MISO=0, rx_data=0, rx_valid=0, cmd_err=0, rd_pending=0, and clear all counters and the shift registers, including in the middle of a frame.
REQ-031 The first frame after reset SHALL be decoded as if no prior traffic occurred.

Structure
REQ-032 The state enum, the cmd encodings (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11) and the DATA_W default SHALL live in package spi_pkg.
REQ-033 The MISO serialiser SHALL be a sub-module spi_tx_shift (load, shift, DATA_W-parameterised).

Verification (DATA_W=8)
REQ-034 Frame 00+0xA5 -> rx_data=10'h0A5, with rx_valid high for exactly 1 cycle, 1 cycle after bit 10.
REQ-035 Frame 10+0x3C, then frame 11+0x00 with tx_valid/tx_data=0x96 -> rx_data 10'h23C then 10'h300; MISO bits 1,0,0,1,0,1,1,0; rd_pending 1 then 0.
REQ-036 With rd_pending=0, frame bits 1,1 -> cmd_err pulse, no rx_valid, state HOLD until SS_n=1.
REQ-037 SS_n deasserted after 5 bits of a write -> no rx_valid, IDLE next cycle; the next full frame decodes correctly.
REQ-038 READ_DATA frame with tx_valid never asserted, TX_TIMEOUT=16 -> cmd_err exactly 16 cycles after entering WAIT_TX, MISO=0.
REQ-039 rst_n=0 during SEND bit 3 -> all outputs 0 next cycle and rd_pending=0.
